// File: rtl/morse_pkg.sv
// morse_pkg: shared definitions for the keyed Morse decoder.
//   - character code constants (SPACE, UNKNOWN)
//   - keyed-entry FSM state enum
//   - decode(len, bits): maps a symbol buffer to a character code.
//     Symbols are shifted in at the LSB, so the first symbol sits at
//     bit len-1. A dash is 1 and a dot is 0. Letters are coded 0-25,
//     digits are coded 26-35, and any other sequence is coded UNKNOWN.
package morse_pkg;

  localparam logic [5:0] CHAR_SPACE   = 6'd36;
  localparam logic [5:0] CHAR_UNKNOWN = 6'd63;

  typedef enum logic [1:0] {
    IDLE,
    MARK,
    SPACE
  } key_state_t;

  // Only the low five bits of the buffer are meaningful. Longer sequences
  // have no table entry, so they decode as UNKNOWN.
  function automatic logic [5:0] decode(input logic [3:0] len, input logic [7:0] bits);
    logic [5:0] code;
    code = CHAR_UNKNOWN;
    case (len)
      4'd1: code = bits[0] ? 6'd19 : 6'd4;                  // T / E
      4'd2:
        case (bits[1:0])
          2'b00:   code = 6'd8;   // I
          2'b01:   code = 6'd0;   // A
          2'b10:   code = 6'd13;  // N
          default: code = 6'd12;  // M
        endcase
      4'd3:
        case (bits[2:0])
          3'b000:  code = 6'd18;  // S
          3'b001:  code = 6'd20;  // U
          3'b010:  code = 6'd17;  // R
          3'b011:  code = 6'd22;  // W
          3'b100:  code = 6'd3;   // D
          3'b101:  code = 6'd10;  // K
          3'b110:  code = 6'd6;   // G
          default: code = 6'd14;  // O
        endcase
      4'd4:
        case (bits[3:0])
          4'b0000: code = 6'd7;   // H
          4'b0001: code = 6'd21;  // V
          4'b0010: code = 6'd5;   // F
          4'b0100: code = 6'd11;  // L
          4'b0110: code = 6'd15;  // P
          4'b0111: code = 6'd9;   // J
          4'b1000: code = 6'd1;   // B
          4'b1001: code = 6'd23;  // X
          4'b1010: code = 6'd2;   // C
          4'b1011: code = 6'd24;  // Y
          4'b1100: code = 6'd25;  // Z
          4'b1101: code = 6'd16;  // Q
          default: code = CHAR_UNKNOWN;
        endcase
      4'd5:
        case (bits[4:0])
          5'b11111: code = 6'd26; // 0
          5'b01111: code = 6'd27; // 1
          5'b00111: code = 6'd28; // 2
          5'b00011: code = 6'd29; // 3
          5'b00001: code = 6'd30; // 4
          5'b00000: code = 6'd31; // 5
          5'b10000: code = 6'd32; // 6
          5'b11000: code = 6'd33; // 7
          5'b11100: code = 6'd34; // 8
          5'b11110: code = 6'd35; // 9
          default:  code = CHAR_UNKNOWN;
        endcase
      default: code = CHAR_UNKNOWN;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/morse_char_fifo.sv
// morse_char_fifo: small character FIFO with a valid/ready read side.
// Ports:
//   clk, rst_n     clock and asynchronous active-low reset
//   push, wdata    write request and data
//   ready          consumer accepts rdata while valid is high
//   rdata          head entry, forced to 0 while empty
//   valid          FIFO non-empty
//   drop           one-cycle pulse after a push was refused because the FIFO was full
// DEPTH must be a power of two (at least 2) so that the pointers wrap naturally.
module morse_char_fifo
  import morse_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             ready,
  output logic [WIDTH-1:0] rdata,
  output logic             valid,
  output logic             drop
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W:0]   count;
  logic             full;
  logic             pop;
  logic             wr_en;

  assign full  = (count == (PTR_W+1)'(DEPTH));
  assign valid = (count != '0);
  assign pop   = valid && ready;
  // A pop in the same cycle frees the slot, so a push into a full FIFO is
  // still accepted. When the FIFO is full, wr_ptr equals rd_ptr. The entry
  // being overwritten is the one that is being popped.
  assign wr_en = push && (!full || pop);
  assign rdata = valid ? mem[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      drop   <= 1'b0;
    end else begin
      drop <= push && !wr_en;
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/morse_keyed_decoder.sv
// morse_keyed_decoder: Morse decoder with two entry modes.
//   Button mode (mode_i = 0): the dot, dash, char_space and word_space buttons
//   act on their rising edges.
//   Keyed mode (mode_i = 1): a straight key is timed in prescaled ticks against
//   a dot unit of UNIT_TICKS. A mark shorter than 2 units is a dot, and a longer
//   mark is a dash. A gap of 3 units ends a character, and a gap of 7 units
//   ends a word.
// Decoded characters are queued in a FIFO and read with a valid/ready handshake.
// Ports:
//   clk, rst_n                    clock and asynchronous active-low reset
//   mode_i, key_i                 entry mode and straight-key level (synchronised)
//   dot_i, dash_i                 button requests (synchronised, edge detected)
//   char_space_i, word_space_i    button requests (synchronised, edge detected)
//   char_o, char_valid_o          FIFO head and non-empty flag
//   char_ready_i                  consumer pops the head when valid
//   drop_o                        pulse when a character is lost to a full FIFO
//   busy_o                        symbol buffer holds a partial character
module morse_keyed_decoder
  import morse_pkg::*;
#(
  parameter int TICK_DIV   = 1000,
  parameter int UNIT_TICKS = 8,
  parameter int MAX_SYMS   = 5,
  parameter int CNT_W      = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       mode_i,
  input  logic       key_i,
  input  logic       dot_i,
  input  logic       dash_i,
  input  logic       char_space_i,
  input  logic       word_space_i,
  output logic [5:0] char_o,
  output logic       char_valid_o,
  input  logic       char_ready_i,
  output logic       drop_o,
  output logic       busy_o
);

  localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int LEN_W = $clog2(MAX_SYMS + 1);
  localparam logic [CNT_W-1:0] DASH_T  = CNT_W'(2 * UNIT_TICKS);
  localparam logic [CNT_W-1:0] CHAR_T  = CNT_W'(3 * UNIT_TICKS);
  localparam logic [CNT_W-1:0] WORD_T  = CNT_W'(7 * UNIT_TICKS);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [PRE_W-1:0] pre;
  logic             tick;
  logic [5:0]       raw;
  logic [5:0]       sync1;
  logic [5:0]       sync2;
  logic [5:0]       stage3;
  logic [3:0]       edges;
  logic             mode_prev;
  logic             mode_lvl;
  logic             key_lvl;
  logic             mode_chg;

  key_state_t       state;
  key_state_t       state_next;
  logic [CNT_W-1:0] cnt;
  logic             cnt_clr;
  logic             char_due;
  logic             word_due;

  logic [LEN_W-1:0]    len;
  logic [MAX_SYMS-1:0] bits;
  logic                ovf;
  logic                ws_pend;

  logic       do_append;
  logic       append_dash;
  logic       do_emit;
  logic       push_space;
  logic       set_pend;
  logic       push;
  logic [5:0] emit_code;
  logic [5:0] push_data;

  // Free-running prescaler. Marks and gaps are measured from an arbitrary
  // phase of this counter, which gives the +/-1 tick uncertainty.
  assign tick = (pre == PRE_W'(TICK_DIV - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    pre <= '0;
    else if (tick) pre <= '0;
    else           pre <= pre + 1'b1;
  end

  // Two synchroniser flops and a third register per input. The third stage
  // is the level seen by the FSM. For buttons, a rising edge becomes a
  // registered one-cycle pulse.
  assign raw = {word_space_i, char_space_i, dash_i, dot_i, key_i, mode_i};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1     <= '0;
      sync2     <= '0;
      stage3    <= '0;
      edges     <= '0;
      mode_prev <= 1'b0;
    end else begin
      sync1     <= raw;
      sync2     <= sync1;
      stage3    <= sync2;
      edges     <= sync2[5:2] & ~stage3[5:2];
      mode_prev <= stage3[0];
    end
  end

  assign mode_lvl = stage3[0];
  assign key_lvl  = stage3[1];
  assign mode_chg = stage3[0] ^ mode_prev;

  // Once len reaches 0 in SPACE, the character has already been emitted.
  // A mark always leaves len >= 1, so no separate "emitted" flag is needed.
  assign char_due = (state == SPACE) && (cnt >= CHAR_T) && (len != '0);
  assign word_due = (state == SPACE) && (cnt >= WORD_T) && !char_due && !key_lvl;

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // FSM next-state logic. In button mode, and on any mode change, the FSM
  // is held in IDLE.
  always_comb begin
    state_next = state;
    if (mode_chg || !mode_lvl) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE:    if (key_lvl) state_next = MARK;
        MARK:    if (!key_lvl) state_next = SPACE;
        SPACE: begin
          if (key_lvl)       state_next = MARK;
          else if (word_due) state_next = IDLE;
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // FSM output logic. This block decides the buffer and FIFO actions for
  // both entry modes. A mode change suppresses every action. The cycle after
  // a word_space that emitted a character is reserved for its SPACE push.
  always_comb begin
    do_append   = 1'b0;
    append_dash = 1'b0;
    do_emit     = 1'b0;
    push_space  = 1'b0;
    set_pend    = 1'b0;
    if (!mode_chg) begin
      if (ws_pend) begin
        push_space = 1'b1;
      end else if (!mode_lvl) begin
        if (edges[3]) begin
          if (len != '0) begin
            do_emit  = 1'b1;
            set_pend = 1'b1;
          end else begin
            push_space = 1'b1;
          end
        end else if (edges[2]) begin
          do_emit = (len != '0);
        end else if (edges[1]) begin
          do_append   = 1'b1;
          append_dash = 1'b1;
        end else if (edges[0]) begin
          do_append = 1'b1;
        end
      end else begin
        case (state)
          MARK: begin
            if (!key_lvl) begin
              do_append   = 1'b1;
              append_dash = (cnt >= DASH_T);
            end
          end
          SPACE: begin
            if (char_due)      do_emit    = 1'b1;
            else if (word_due) push_space = 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  // The mark/gap counter restarts on every state change. It counts ticks
  // only in MARK and SPACE, and it saturates so that a held key stays a dash.
  assign cnt_clr = (state_next != state) || (state == IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                          cnt <= '0;
    else if (cnt_clr)                    cnt <= '0;
    else if (tick && (cnt != CNT_MAX))   cnt <= cnt + 1'b1;
  end

  // Symbol buffer. An append to a full buffer is not stored; it only sets
  // ovf, which turns the emitted code into UNKNOWN. A mode change discards
  // the partial character and any pending word SPACE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len     <= '0;
      bits    <= '0;
      ovf     <= 1'b0;
      ws_pend <= 1'b0;
    end else begin
      ws_pend <= set_pend;
      if (mode_chg || do_emit) begin
        len  <= '0;
        bits <= '0;
        ovf  <= 1'b0;
      end else if (do_append) begin
        if (len == LEN_W'(MAX_SYMS)) begin
          ovf <= 1'b1;
        end else begin
          bits <= {bits[MAX_SYMS-2:0], append_dash};
          len  <= len + 1'b1;
        end
      end
    end
  end

  assign emit_code = ovf ? CHAR_UNKNOWN : decode(4'(len), 8'(bits));
  assign push      = do_emit || push_space;
  assign push_data = push_space ? CHAR_SPACE : emit_code;
  assign busy_o    = (len != '0);

  morse_char_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (6)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .wdata (push_data),
    .ready (char_ready_i),
    .rdata (char_o),
    .valid (char_valid_o),
    .drop  (drop_o)
  );

endmodule

// File: tb/tb_morse_keyed_decoder.sv
// tb_morse_keyed_decoder: directed bench for morse_keyed_decoder.
// The DUT uses TICK_DIV = 4, UNIT_TICKS = 4, MAX_SYMS = 5, FIFO_DEPTH = 4.
// Button-mode characters come from a vector table. The bench also runs
// hand-written sequences for reset, latency, word space, mode switching,
// keyed timing, and FIFO overflow.
module tb_morse_keyed_decoder;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       mode_i = 1'b0;
  logic       key_i = 1'b0;
  logic       dot_i = 1'b0;
  logic       dash_i = 1'b0;
  logic       char_space_i = 1'b0;
  logic       word_space_i = 1'b0;
  logic       char_ready_i = 1'b0;
  logic [5:0] char_o;
  logic       char_valid_o;
  logic       drop_o;
  logic       busy_o;

  int checks = 0;
  int failures = 0;
  int drop_seen = 0;

  // One button-mode character: symbols (first symbol at bit nsyms-1,
  // dash = 1), terminator (char_space or word_space), and the expected code.
  typedef struct {
    string      name;
    int         nsyms;
    logic [7:0] pat;
    logic       word;
    int         exp_char;
  } vec_t;

  vec_t vecs[12];
  vec_t fill[5];

  morse_keyed_decoder #(
    .TICK_DIV   (4),
    .UNIT_TICKS (4),
    .MAX_SYMS   (5),
    .CNT_W      (8),
    .FIFO_DEPTH (4)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .mode_i       (mode_i),
    .key_i        (key_i),
    .dot_i        (dot_i),
    .dash_i       (dash_i),
    .char_space_i (char_space_i),
    .word_space_i (word_space_i),
    .char_o       (char_o),
    .char_valid_o (char_valid_o),
    .char_ready_i (char_ready_i),
    .drop_o       (drop_o),
    .busy_o       (busy_o)
  );

  always #5 clk = ~clk;

  // drop_o is registered on posedge, so a mid-cycle sample counts every pulse cycle.
  always @(negedge clk) begin
    if (rst_n && drop_o) drop_seen = drop_seen + 1;
  end

  // Global time limit.
  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  // Hold one button high for 2 cycles, then low for 2 cycles.
  // 0 = dot, 1 = dash, 2 = char_space, 3 = word_space.
  task automatic press(input int which);
    case (which)
      0:       dot_i = 1'b1;
      1:       dash_i = 1'b1;
      2:       char_space_i = 1'b1;
      default: word_space_i = 1'b1;
    endcase
    step(2);
    dot_i = 1'b0;
    dash_i = 1'b0;
    char_space_i = 1'b0;
    word_space_i = 1'b0;
    step(2);
  endtask

  task automatic applyStimulus(input vec_t v);
    for (int i = v.nsyms - 1; i >= 0; i--) press(v.pat[i] ? 1 : 0);
    press(v.word ? 3 : 2);
  endtask

  task automatic waitValid(input string name, input int limit);
    int n;
    n = 0;
    while (!char_valid_o && n < limit) begin
      step(1);
      n++;
    end
    checkOutput({name, " valid"}, {31'd0, char_valid_o}, 32'd1);
  endtask

  task automatic popOne;
    char_ready_i = 1'b1;
    step(1);
    char_ready_i = 1'b0;
  endtask

  initial begin
    int lat;
    int seen;
    int c;
    int drain_exp[4];

    vecs[0]  = '{"A",       2, 8'b00000001, 1'b0, 0};
    vecs[1]  = '{"E",       1, 8'b00000000, 1'b0, 4};
    vecs[2]  = '{"T",       1, 8'b00000001, 1'b0, 19};
    vecs[3]  = '{"K",       3, 8'b00000101, 1'b0, 10};
    vecs[4]  = '{"Q",       4, 8'b00001101, 1'b0, 16};
    vecs[5]  = '{"Z",       4, 8'b00001100, 1'b0, 25};
    vecs[6]  = '{"digit0",  5, 8'b00011111, 1'b0, 26};
    vecs[7]  = '{"digit5",  5, 8'b00000000, 1'b0, 31};
    vecs[8]  = '{"digit9",  5, 8'b00011110, 1'b0, 35};
    vecs[9]  = '{"sixdots", 6, 8'b00000000, 1'b0, 63};
    vecs[10] = '{"unk4",    4, 8'b00000011, 1'b0, 63};
    vecs[11] = '{"wsalone", 0, 8'b00000000, 1'b1, 36};

    fill[0] = '{"fillE", 1, 8'b00000000, 1'b0, 4};
    fill[1] = '{"fillT", 1, 8'b00000001, 1'b0, 19};
    fill[2] = '{"fillI", 2, 8'b00000000, 1'b0, 8};
    fill[3] = '{"fillM", 2, 8'b00000011, 1'b0, 12};
    fill[4] = '{"fillN", 2, 8'b00000010, 1'b0, 13};
    drain_exp = '{4, 19, 8, 12};

    // Reset with inputs toggling, then a quiet release.
    rst_n = 1'b0;
    for (int i = 0; i < 8; i++) begin
      {mode_i, key_i, dot_i, dash_i, char_space_i, word_space_i, char_ready_i} = 7'($urandom);
      step(1);
    end
    checkOutput("reset char_o", {26'd0, char_o}, 32'd0);
    checkOutput("reset char_valid_o", {31'd0, char_valid_o}, 32'd0);
    checkOutput("reset drop_o", {31'd0, drop_o}, 32'd0);
    checkOutput("reset busy_o", {31'd0, busy_o}, 32'd0);
    {mode_i, key_i, dot_i, dash_i, char_space_i, word_space_i, char_ready_i} = '0;
    step(1);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      step(1);
      if (char_valid_o) seen++;
    end
    checkOutput("post-reset valid cycles", seen, 0);

    // "A": char_valid_o rises 4 cycles after char_space rises.
    press(0);
    press(1);
    checkOutput("busy after A symbols", {31'd0, busy_o}, 32'd1);
    char_space_i = 1'b1;
    lat = 0;
    while (!char_valid_o && lat < 20) begin
      step(1);
      lat++;
    end
    char_space_i = 1'b0;
    checkOutput("char_space latency", lat, 4);
    checkOutput("latency char A", {26'd0, char_o}, 32'd0);
    step(2);
    popOne;
    step(2);

    // Table-driven button-mode characters.
    for (int k = 0; k < 12; k++) begin
      applyStimulus(vecs[k]);
      waitValid(vecs[k].name, 40);
      checkOutput(vecs[k].name, {26'd0, char_o}, vecs[k].exp_char);
      popOne;
      step(2);
      checkOutput({vecs[k].name, " empty"}, {31'd0, char_valid_o}, 32'd0);
      checkOutput({vecs[k].name, " busy"}, {31'd0, busy_o}, 32'd0);
    end

    // word_space after "N": N first, then SPACE on the next cycle.
    press(1);
    press(0);
    press(3);
    waitValid("word N", 40);
    checkOutput("word N char", {26'd0, char_o}, 32'd13);
    popOne;
    checkOutput("word space valid", {31'd0, char_valid_o}, 32'd1);
    checkOutput("word space char", {26'd0, char_o}, 32'd36);
    popOne;
    step(2);
    checkOutput("word empty", {31'd0, char_valid_o}, 32'd0);

    // Mode switch mid-character discards the partial character.
    press(0);
    press(0);
    checkOutput("busy before mode switch", {31'd0, busy_o}, 32'd1);
    mode_i = 1'b1;
    step(6);
    checkOutput("busy after mode switch", {31'd0, busy_o}, 32'd0);
    mode_i = 1'b0;
    step(6);
    checkOutput("no push on mode switch", {31'd0, char_valid_o}, 32'd0);
    press(0);
    press(2);
    waitValid("after switch E", 40);
    checkOutput("after switch E char", {26'd0, char_o}, 32'd4);
    popOne;
    step(2);

    // Keyed mode: 4-tick mark, 4-tick gap, 12-tick mark, then key up.
    mode_i = 1'b1;
    step(6);
    key_i = 1'b1;
    step(16);
    key_i = 1'b0;
    step(16);
    key_i = 1'b1;
    step(48);
    key_i = 1'b0;
    c = 0;
    while (!char_valid_o && c < 80) begin
      step(1);
      c++;
    end
    checkOutput("keyed A valid", {31'd0, char_valid_o}, 32'd1);
    checkOutput("keyed A char", {26'd0, char_o}, 32'd0);
    checkOutput("keyed A timing in [44,60]", {31'd0, (c >= 44 && c <= 60)}, 32'd1);
    popOne;
    c++;
    while (!char_valid_o && c < 200) begin
      step(1);
      c++;
    end
    checkOutput("keyed space valid", {31'd0, char_valid_o}, 32'd1);
    checkOutput("keyed space char", {26'd0, char_o}, 32'd36);
    checkOutput("keyed space timing in [104,126]", {31'd0, (c >= 104 && c <= 126)}, 32'd1);
    popOne;
    mode_i = 1'b0;
    step(6);

    // FIFO full: 5 pushes with no reads, then drain.
    drop_seen = 0;
    for (int k = 0; k < 4; k++) applyStimulus(fill[k]);
    step(4);
    checkOutput("no drop while filling", drop_seen, 0);
    applyStimulus(fill[4]);
    step(4);
    checkOutput("drop pulse cycles", drop_seen, 1);
    checkOutput("full head", {26'd0, char_o}, 32'd4);
    char_ready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("drain%0d valid", i), {31'd0, char_valid_o}, 32'd1);
      checkOutput($sformatf("drain%0d char", i), {26'd0, char_o}, drain_exp[i]);
      step(1);
    end
    char_ready_i = 1'b0;
    checkOutput("drain empty", {31'd0, char_valid_o}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
